// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU (m0) and a debug/DMA loader (m1).
// Grants are combinational in the request cycle; read data returns registered one cycle later.
module dm_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic [31:0]       m0_pc,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic [31:0]       m1_pc,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic [31:0]       mem_pc,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [1:0]        owner
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } fsmState_t;

    fsmState_t        stateReg, stateNext;
    logic             lastReg, lastNext;
    logic [CNT_W-1:0] burstCntReg, burstCntNext;
    logic [CNT_W-1:0] burstCntInc;
    logic             gnt0, gnt1;

    logic [1:0]        gntVec;
    logic [1:0]        weVec;
    logic [1:0]        rvalidReg;
    logic [DATA_W-1:0] rdataReg [2];

    assign burstCntInc = (burstCntReg == BURST_LAST) ? burstCntReg
                                                     : burstCntReg + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg    <= IDLE;
            lastReg     <= 1'b1;
            burstCntReg <= '0;
        end else begin
            stateReg    <= stateNext;
            lastReg     <= lastNext;
            burstCntReg <= burstCntNext;
        end
    end

    // Grant decision plus next-state; nothing is granted while reset is held low.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        stateNext    = IDLE;
        lastNext     = lastReg;
        burstCntNext = '0;
        if (reset) begin
            if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                case (stateReg)
                    OWN0: begin
                        if (burstCntReg < BURST_LAST) gnt0 = 1'b1;
                        else                          gnt1 = 1'b1;
                    end
                    OWN1: begin
                        if (burstCntReg < BURST_LAST) gnt1 = 1'b1;
                        else                          gnt0 = 1'b1;
                    end
                    default: begin
                        if (lastReg) gnt0 = 1'b1;
                        else         gnt1 = 1'b1;
                    end
                endcase
            end
        end
        if (gnt0) begin
            stateNext    = OWN0;
            lastNext     = 1'b0;
            burstCntNext = (stateReg == OWN0) ? burstCntInc : '0;
        end else if (gnt1) begin
            stateNext    = OWN1;
            lastNext     = 1'b1;
            burstCntNext = (stateReg == OWN1) ? burstCntInc : '0;
        end
    end

    // Memory-side mux: an ungranted port is driven fully to zero.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        mem_pc   = '0;
        if (gnt0) begin
            mem_we   = m0_we;
            mem_addr = m0_addr;
            mem_wd   = m0_wd;
            mem_pc   = m0_pc;
        end else if (gnt1) begin
            mem_we   = m1_we;
            mem_addr = m1_addr;
            mem_wd   = m1_wd;
            mem_pc   = m1_pc;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign owner  = {gnt1, gnt0};
    assign gntVec = {gnt1, gnt0};
    assign weVec  = {m1_we, m0_we};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gReadReturn
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rvalidReg[gi] <= 1'b0;
                    rdataReg[gi]  <= '0;
                end else begin
                    rvalidReg[gi] <= gntVec[gi] && !weVec[gi];
                    if (gntVec[gi] && !weVec[gi]) begin
                        rdataReg[gi] <= mem_rd;
                    end
                end
            end
        end
    endgenerate

    assign m0_rvalid = rvalidReg[0];
    assign m1_rvalid = rvalidReg[1];
    assign m0_rdata  = rdataReg[0];
    assign m1_rdata  = rdataReg[1];

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: a behavioural DM sits on the memory port, and a
// second instance with MAX_BURST=1 checks strict alternation.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m0_pc, m1_addr, m1_wd, m1_pc;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_pc, mem_rd;
    logic [1:0]  owner;

    logic        alt_m0_gnt, alt_m0_rvalid, alt_m1_gnt, alt_m1_rvalid, alt_mem_we;
    logic [31:0] alt_m0_rdata, alt_m1_rdata, alt_mem_addr, alt_mem_wd, alt_mem_pc;
    logic [1:0]  alt_owner;
    logic [31:0] alt_mem_rd;

    logic [31:0] dmem [0:4095];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_pc(m0_pc),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_pc(m1_pc),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_pc(mem_pc),
        .mem_rd(mem_rd), .owner(owner)
    );

    dm_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(1)) u_alt (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_pc(m0_pc),
        .m0_gnt(alt_m0_gnt), .m0_rvalid(alt_m0_rvalid), .m0_rdata(alt_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_pc(m1_pc),
        .m1_gnt(alt_m1_gnt), .m1_rvalid(alt_m1_rvalid), .m1_rdata(alt_m1_rdata),
        .mem_we(alt_mem_we), .mem_addr(alt_mem_addr), .mem_wd(alt_mem_wd), .mem_pc(alt_mem_pc),
        .mem_rd(alt_mem_rd), .owner(alt_owner)
    );

    assign alt_mem_rd = 32'h0;

    // Behavioural DM: combinational read, write visible the cycle after the edge.
    assign mem_rd = dmem[mem_addr[13:2]];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[13:2]] <= mem_wd;
    end

    task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] pc);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wd = wd; m0_pc = pc;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] pc);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wd = wd; m1_pc = pc;
    endtask

    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_m0(1'b1, 1'b1, 32'h10, 32'h1, 32'h4);
        @(negedge clk);
        vectors++; if (m0_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_gnt got %b exp 0", m0_gnt); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL rst_owner got %b exp 00", owner); end
        vectors++; if (m0_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got %b exp 0", m0_rvalid); end
        vectors++; if (m0_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h exp 0", m0_rdata); end
        $display("test_reset: outputs quiet while reset low with m0 requesting");
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        next_slot();
    endtask

    task automatic test_mid_read_reset();
        drive_m0(1'b1, 1'b0, 32'h40, 32'h0, 32'h8);
        @(negedge clk);
        vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL t1_gnt got %b exp 1", m0_gnt); end
        vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("FAIL t1_addr got %h exp 40", mem_addr); end
        next_slot();
        reset = 1'b0;
        #1;
        vectors++; if (m0_rvalid !== 1'b0) begin miscompares++; $display("FAIL t1_rvalid_lost got %b exp 0", m0_rvalid); end
        vectors++; if (m0_rdata !== 32'h0) begin miscompares++; $display("FAIL t1_rdata_clr got %h exp 0", m0_rdata); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL t1_mem_we got %b exp 0", mem_we); end
        $display("test_mid_read_reset: reset after read grant, rvalid=%b", m0_rvalid);
        drive_m1(1'b1, 1'b0, 32'h44, 32'h0, 32'hC);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL t4_m0_gnt got %b exp 1", m0_gnt); end
        vectors++; if (m1_gnt !== 1'b0) begin miscompares++; $display("FAIL t4_m1_gnt got %b exp 0", m1_gnt); end
        vectors++; if (owner !== 2'b01) begin miscompares++; $display("FAIL t4_owner got %b exp 01", owner); end
        next_slot();
        vectors++; if (m0_rvalid !== 1'b1) begin miscompares++; $display("FAIL t4_rvalid got %b exp 1", m0_rvalid); end
        vectors++; if (m0_rdata !== 32'h1234) begin miscompares++; $display("FAIL t4_rdata got %h exp 1234", m0_rdata); end
        vectors++; if (m1_rvalid !== 1'b0) begin miscompares++; $display("FAIL t4_m1_rvalid got %b exp 0", m1_rvalid); end
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        vectors++; if (m1_gnt !== 1'b1) begin miscompares++; $display("FAIL t4_m1_held got %b exp 1", m1_gnt); end
        vectors++; if (owner !== 2'b10) begin miscompares++; $display("FAIL t4_owner2 got %b exp 10", owner); end
        next_slot();
        vectors++; if (m1_rvalid !== 1'b1) begin miscompares++; $display("FAIL t4_m1_rvalid got %b exp 1", m1_rvalid); end
        vectors++; if (m1_rdata !== 32'hABCD) begin miscompares++; $display("FAIL t4_m1_rdata got %h exp abcd", m1_rdata); end
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        next_slot();
        vectors++; if (m1_rvalid !== 1'b0) begin miscompares++; $display("FAIL t4_m1_rvalid_pulse got %b exp 0", m1_rvalid); end
        $display("test_mid_read_reset: m0 won first after release, m1 read %h", m1_rdata);
    endtask

    task automatic test_write_read();
        drive_m0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h100);
        @(negedge clk);
        vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL t2_gnt got %b exp 1", m0_gnt); end
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL t2_we got %b exp 1", mem_we); end
        vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL t2_addr got %h exp 10", mem_addr); end
        vectors++; if (mem_wd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL t2_wd got %h exp deadbeef", mem_wd); end
        vectors++; if (mem_pc !== 32'h100) begin miscompares++; $display("FAIL t2_pc got %h exp 100", mem_pc); end
        next_slot();
        vectors++; if (m0_rvalid !== 1'b0) begin miscompares++; $display("FAIL t2_wr_rvalid got %b exp 0", m0_rvalid); end
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 32'h104);
        @(negedge clk);
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL t2_rd_we got %b exp 0", mem_we); end
        vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL t2_rd_gnt got %b exp 1", m0_gnt); end
        next_slot();
        vectors++; if (m0_rvalid !== 1'b1) begin miscompares++; $display("FAIL t2_rvalid got %b exp 1", m0_rvalid); end
        vectors++; if (m0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL t2_rdata got %h exp deadbeef", m0_rdata); end
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        next_slot();
        vectors++; if (m0_rvalid !== 1'b0) begin miscompares++; $display("FAIL t2_rvalid_pulse got %b exp 0", m0_rvalid); end
        $display("test_write_read: m0 wrote and read back %h", m0_rdata);
    endtask

    task automatic test_burst();
        logic [1:0] exp_owner [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                       2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        logic [1:0] exp_alt;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        drive_m0(1'b1, 1'b1, 32'h80, 32'h11, 32'h200);
        drive_m1(1'b1, 1'b1, 32'h84, 32'h22, 32'h300);
        for (int i = 0; i < 10; i++) begin
            exp_alt = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            vectors++;
            if (owner !== exp_owner[i]) begin
                miscompares++; $display("FAIL t3_owner[%0d] got %b exp %b", i, owner, exp_owner[i]);
            end
            vectors++;
            if (alt_owner !== exp_alt) begin
                miscompares++; $display("FAIL t3_alt_owner[%0d] got %b exp %b", i, alt_owner, exp_alt);
            end
            $display("test_burst: cycle %0d owner=%b alt_owner=%b", i, owner, alt_owner);
            next_slot();
        end
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        next_slot();
    endtask

    task automatic test_raw();
        drive_m0(1'b1, 1'b1, 32'h20, 32'h5, 32'h400);
        @(negedge clk);
        vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL t5_wr_gnt got %b exp 1", m0_gnt); end
        next_slot();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive_m1(1'b1, 1'b0, 32'h20, 32'h0, 32'h500);
        @(negedge clk);
        vectors++; if (m1_gnt !== 1'b1) begin miscompares++; $display("FAIL t5_rd_gnt got %b exp 1", m1_gnt); end
        vectors++; if (mem_pc !== 32'h500) begin miscompares++; $display("FAIL t5_pc got %h exp 500", mem_pc); end
        next_slot();
        vectors++; if (m1_rvalid !== 1'b1) begin miscompares++; $display("FAIL t5_rvalid got %b exp 1", m1_rvalid); end
        vectors++; if (m1_rdata !== 32'h5) begin miscompares++; $display("FAIL t5_rdata got %h exp 5", m1_rdata); end
        vectors++; if (m0_rvalid !== 1'b0) begin miscompares++; $display("FAIL t5_m0_rvalid got %b exp 0", m0_rvalid); end
        $display("test_raw: m1 read after m0 write returned %h", m1_rdata);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_idle();
        logic [1:0] exp_owner [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL t6_owner[%0d] got %b exp 00", i, owner); end
            vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL t6_we[%0d] got %b exp 0", i, mem_we); end
            vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL t6_addr[%0d] got %h exp 0", i, mem_addr); end
            $display("test_idle: idle cycle %0d owner=%b", i, owner);
            next_slot();
        end
        drive_m1(1'b1, 1'b1, 32'h30, 32'h7, 32'h600);
        @(negedge clk);
        vectors++; if (m1_gnt !== 1'b1) begin miscompares++; $display("FAIL t6_m1_gnt got %b exp 1", m1_gnt); end
        vectors++; if (owner !== 2'b10) begin miscompares++; $display("FAIL t6_m1_owner got %b exp 10", owner); end
        next_slot();
        drive_m0(1'b1, 1'b1, 32'h34, 32'h8, 32'h700);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (owner !== exp_owner[i]) begin
                miscompares++; $display("FAIL t6_burst[%0d] got %b exp %b", i, owner, exp_owner[i]);
            end
            $display("test_idle: contention cycle %0d owner=%b", i, owner);
            next_slot();
        end
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        next_slot();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) dmem[i] = 32'h0;
        dmem[32'h40 >> 2] = 32'h1234;
        dmem[32'h44 >> 2] = 32'hABCD;
        reset = 1'b0;
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        next_slot();
        test_reset();
        test_mid_read_reset();
        test_write_read();
        test_burst();
        test_raw();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
